veririsc_core: RTL and testbench

//  Parametrised next-generation VeriRISC processor core: 8-opcode accumulator ISA, external memory bus with req/ack wait states.

---
 rtl/veririsc_pkg.sv | 27 ++
 rtl/veririsc_if.sv | 22 ++
 rtl/veririsc_alu.sv | 26 ++
 rtl/veririsc_core.sv | 125 ++++++++++++
 tb/tb_veririsc_core.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/veririsc_pkg.sv
// Shared definitions for the VeriRISC accumulator core: opcodes and FSM state encoding.
package veririsc_pkg;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  typedef enum logic [2:0] {
    BOOT,
    FETCH,
    DECODE,
    OPERAND,
    STORE,
    HALTED
  } state_t;

  // States in which the core owns an outstanding bus transaction.
  function automatic logic is_bus_state(input state_t s);
    return (s == FETCH) || (s == OPERAND) || (s == STORE);
  endfunction

endpackage

// File: rtl/veririsc_if.sv
// Request/acknowledge memory bus between the VeriRISC core (master) and memory (slave).
interface veririsc_if #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned AWIDTH = 5
);
  logic              mem_req;
  logic              mem_we;
  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_wdata;
  logic [DWIDTH-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/veririsc_alu.sv
// Combinational accumulator datapath: ADD/AND/XOR/LDA result and accumulator zero flag.
module veririsc_alu
  import veririsc_pkg::*;
#(
  parameter int unsigned DWIDTH = 8
) (
  input  logic [2:0]        op,
  input  logic [DWIDTH-1:0] a,
  input  logic [DWIDTH-1:0] b,
  output logic [DWIDTH-1:0] result_c,
  output logic              a_is_zero
);

  always_comb begin
    result_c = b;
    case (op)
      OP_ADD:  result_c = a + b;
      OP_AND:  result_c = a & b;
      OP_XOR:  result_c = a ^ b;
      default: result_c = b;
    endcase
  end

  assign a_is_zero = (a == '0);

endmodule

// File: rtl/veririsc_core.sv
// VeriRISC accumulator core with a variable-length FSM over a req/ack memory bus.
// Optional VERIRISC_RESUME_EN adds a 'resume' input that restarts fetching from HALTED.
module veririsc_core
  import veririsc_pkg::*;
#(
  parameter int unsigned DWIDTH   = 8,
  parameter int unsigned AWIDTH   = 5,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
`ifdef VERIRISC_RESUME_EN
  input  logic              resume,
`endif
  veririsc_if.master        bus,
  output logic              halt,
  output logic [AWIDTH-1:0] pc_out
);

  state_t            state, state_nxt;
  logic [AWIDTH-1:0] pc, pc_nxt;
  logic [DWIDTH-1:0] ir, ir_nxt;
  logic [DWIDTH-1:0] ac, ac_nxt;
  logic              req_q, we_q;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] alu_result;
  logic              ac_zero;
  logic [2:0]        opcode;
  logic [AWIDTH-1:0] operand;
  logic              xfer;

  assign opcode  = ir[DWIDTH-1 -: 3];
  assign operand = ir[AWIDTH-1:0];
  assign xfer    = req_q & bus.mem_ack;

  veririsc_alu #(.DWIDTH(DWIDTH)) u_alu (
    .op        (opcode),
    .a         (ac),
    .b         (bus.mem_rdata),
    .result_c  (alu_result),
    .a_is_zero (ac_zero)
  );

  // Next-state and architectural register updates.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ir_nxt    = ir;
    ac_nxt    = ac;
    case (state)
      BOOT: state_nxt = FETCH;
      FETCH: begin
        if (xfer) begin
          ir_nxt    = bus.mem_rdata;
          state_nxt = DECODE;
        end
      end
      DECODE: begin
        pc_nxt = pc + AWIDTH'(1);
        case (opcode)
          OP_HLT: state_nxt = HALTED;
          OP_SKZ: begin
            if (ac_zero) pc_nxt = pc + AWIDTH'(2);
            state_nxt = FETCH;
          end
          OP_JMP: begin
            pc_nxt    = operand;
            state_nxt = FETCH;
          end
          OP_STO:  state_nxt = STORE;
          default: state_nxt = OPERAND;
        endcase
      end
      OPERAND: begin
        if (xfer) begin
          ac_nxt    = alu_result;
          state_nxt = FETCH;
        end
      end
      STORE: begin
        if (xfer) state_nxt = FETCH;
      end
      HALTED: begin
`ifdef VERIRISC_RESUME_EN
        if (resume) state_nxt = FETCH;
`endif
      end
      default: state_nxt = BOOT;
    endcase
  end

  // Bus outputs are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= BOOT;
      pc     <= AWIDTH'(RESET_PC);
      ir     <= '0;
      ac     <= '0;
      req_q  <= 1'b0;
      we_q   <= 1'b0;
      addr_q <= '0;
      halt   <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      ir    <= ir_nxt;
      ac    <= ac_nxt;
      req_q <= is_bus_state(state_nxt);
      we_q  <= (state_nxt == STORE);
      halt  <= (state_nxt == HALTED);
      case (state_nxt)
        FETCH:          addr_q <= pc_nxt;
        OPERAND, STORE: addr_q <= ir_nxt[AWIDTH-1:0];
        default:        addr_q <= '0;
      endcase
    end
  end

  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = ac;
  assign pc_out        = pc;

endmodule

// File: tb/tb_veririsc_core.sv
// Bench for veririsc_core: directed program table, reset-abort sequence and random programs vs an ISA model.
module tb_veririsc_core;
  import veririsc_pkg::*;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 5;
  localparam int unsigned DEPTH = 32;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  typedef struct packed {
    logic [3:0][DW-1:0] code;
    logic [DW-1:0]      w31;
    logic [DW-1:0]      d10;
    logic [DW-1:0]      d11;
    logic [AW-1:0]      chk_addr;
    logic [DW-1:0]      chk_val;
    logic [AW-1:0]      halt_pc;
    logic [7:0]         cycles;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
`ifdef VERIRISC_RESUME_EN
  logic          resume = 1'b0;
`endif
  logic          halt;
  logic [AW-1:0] pc_out;

  veririsc_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

  veririsc_core #(.DWIDTH(DW), .AWIDTH(AW), .RESET_PC(0)) dut (
    .clk    (clk),
    .rst    (rst),
`ifdef VERIRISC_RESUME_EN
    .resume (resume),
`endif
    .bus    (bus),
    .halt   (halt),
    .pc_out (pc_out)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] img     [DEPTH];
  txn_t          obs_q[$];
  txn_t          exp_q[$];
  int            total = 0;
  int            bad   = 0;

  bit            in_txn = 1'b0;
  logic          t_we;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_wdata;
  int            wait_left = 0;
  int            max_wait  = 0;
  bit            stall     = 1'b0;
  logic [AW-1:0] stall_addr = '0;
  bit            noise     = 1'b0;

  function automatic logic [DW-1:0] enc(input logic [2:0] op, input logic [AW-1:0] a);
    return {op, a};
  endfunction

  function automatic vec_t mkvec(input logic [DW-1:0] c0, c1, c2, c3, w31, d10, d11,
                                 input logic [AW-1:0] chk_addr, input logic [DW-1:0] chk_val,
                                 input logic [AW-1:0] halt_pc, input logic [7:0] cycles);
    vec_t v;
    v.code     = {c3, c2, c1, c0};
    v.w31      = w31;
    v.d10      = d10;
    v.d11      = d11;
    v.chk_addr = chk_addr;
    v.chk_val  = chk_val;
    v.halt_pc  = halt_pc;
    v.cycles   = cycles;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Memory slave: acts on the falling edge, random wait states, optional stall and idle-ack noise.
  task automatic respond();
    txn_t t;
    if (bus.mem_req && !(stall && bus.mem_addr == stall_addr)) begin
      if (!in_txn) begin
        in_txn    = 1'b1;
        t_we      = bus.mem_we;
        t_addr    = bus.mem_addr;
        t_wdata   = bus.mem_wdata;
        wait_left = int'($urandom_range(max_wait, 0));
      end else begin
        check("bus_stable", 32'({bus.mem_we, bus.mem_addr, bus.mem_wdata}),
              32'({t_we, t_addr, t_wdata}));
      end
      if (wait_left == 0) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = t_we ? DW'($urandom) : mem[t_addr];
        if (!rst) begin
          if (t_we) mem[t_addr] = t_wdata;
          t.we   = t_we;
          t.addr = t_addr;
          t.data = t_we ? t_wdata : bus.mem_rdata;
          obs_q.push_back(t);
        end
        in_txn = 1'b0;
      end else begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = DW'($urandom);
        wait_left--;
      end
    end else begin
      bus.mem_ack   = (noise && !bus.mem_req) ? 1'($urandom) : 1'b0;
      bus.mem_rdata = DW'($urandom);
      if (!bus.mem_req) in_txn = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    respond();
    @(posedge clk);
    #1;
  endtask

  // Instruction-level ISA interpreter over img; fills ref_mem, exp_q and a zero-wait cycle count.
  task automatic model_run(output bit halted, output logic [AW-1:0] hpc, output int cyc);
    logic [DW-1:0] ac, w, opnd;
    logic [AW-1:0] pc, a;
    txn_t          t;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = img[i];
    exp_q.delete();
    ac = '0; pc = '0; cyc = 1; halted = 1'b0;
    for (int n = 0; n < 100 && !halted; n++) begin
      w = ref_mem[pc];
      a = w[AW-1:0];
      t.we = 1'b0; t.addr = pc; t.data = w;
      exp_q.push_back(t);
      pc = pc + AW'(1);
      case (w[DW-1 -: 3])
        OP_HLT: begin halted = 1'b1; cyc += 2; end
        OP_SKZ: begin if (ac == '0) pc = pc + AW'(1); cyc += 2; end
        OP_JMP: begin pc = a; cyc += 2; end
        OP_STO: begin
          t.we = 1'b1; t.addr = a; t.data = ac;
          exp_q.push_back(t);
          ref_mem[a] = ac;
          cyc += 3;
        end
        default: begin
          opnd = ref_mem[a];
          t.we = 1'b0; t.addr = a; t.data = opnd;
          exp_q.push_back(t);
          case (w[DW-1 -: 3])
            OP_ADD:  ac = ac + opnd;
            OP_AND:  ac = ac & opnd;
            OP_XOR:  ac = ac ^ opnd;
            default: ac = opnd;
          endcase
          cyc += 3;
        end
      endcase
    end
    hpc = pc;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    check("rst_req",  32'(bus.mem_req),  32'd0);
    check("rst_we",   32'(bus.mem_we),   32'd0);
    check("rst_halt", 32'(halt),         32'd0);
    check("rst_pc",   32'(pc_out),       32'd0);
    check("rst_addr", 32'(bus.mem_addr), 32'd0);
    for (int i = 0; i < DEPTH; i++) mem[i] = img[i];
    obs_q.delete();
    in_txn = 1'b0;
    rst = 1'b0;
  endtask

  task automatic run_to_halt(input int mw, input logic [AW-1:0] exp_hpc, input int exp_cyc,
                             input string nm);
    int cyc = 0;
    int n, k;
    max_wait = mw;
    while (!halt && cyc < 3000) begin
      tick();
      cyc++;
    end
    check({nm, "_halted"}, 32'(halt), 32'd1);
    if (exp_cyc != 0) check({nm, "_cycles"}, 32'(cyc), 32'(exp_cyc));
    check({nm, "_pc"}, 32'(pc_out), 32'(exp_hpc));
    repeat (3) begin
      tick();
      check({nm, "_idle"}, 32'(bus.mem_req), 32'd0);
    end
    check({nm, "_ntxn"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    k = 0;
    while (k < n - 1 && obs_q[k] === exp_q[k]) k++;
    if (n > 0) check({nm, "_txn"}, 32'(obs_q[k]), 32'(exp_q[k]));
    k = 0;
    while (k < DEPTH - 1 && mem[k] === ref_mem[k]) k++;
    check({nm, "_mem"}, 32'(mem[k]), 32'(ref_mem[k]));
  endtask

  initial begin
    vec_t          vecs [7];
    bit            m_halted;
    logic [AW-1:0] m_hpc;
    int            m_cyc;
    int            found;
    int            done, tries;

    rst = 1'b1;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;

    vecs[0] = mkvec(enc(OP_LDA,10), enc(OP_ADD,11), enc(OP_STO,12), enc(OP_HLT,0), 8'h00,
                    8'd3, 8'd4, 5'd12, 8'd7, 5'd4, 8'd12);
    vecs[1] = mkvec(enc(OP_LDA,10), enc(OP_ADD,11), enc(OP_STO,12), enc(OP_HLT,0), 8'h00,
                    8'hFF, 8'h02, 5'd12, 8'h01, 5'd4, 8'd12);
    vecs[2] = mkvec(enc(OP_LDA,10), enc(OP_XOR,11), enc(OP_STO,12), enc(OP_HLT,0), 8'h00,
                    8'hA5, 8'h0F, 5'd12, 8'hAA, 5'd4, 8'd12);
    vecs[3] = mkvec(enc(OP_LDA,10), enc(OP_AND,11), enc(OP_STO,12), enc(OP_HLT,0), 8'h00,
                    8'hA5, 8'h0F, 5'd12, 8'h05, 5'd4, 8'd12);
    vecs[4] = mkvec(enc(OP_SKZ,0), enc(OP_JMP,20), enc(OP_HLT,0), enc(OP_HLT,0), 8'h00,
                    8'h00, 8'h00, 5'd12, 8'h00, 5'd3, 8'd5);
    vecs[5] = mkvec(enc(OP_LDA,10), enc(OP_SKZ,0), enc(OP_JMP,20), enc(OP_HLT,0), 8'h00,
                    8'h01, 8'h00, 5'd10, 8'h01, 5'd21, 8'd10);
    vecs[6] = mkvec(enc(OP_SKZ,0), enc(OP_HLT,0), enc(OP_JMP,31), enc(OP_HLT,0), enc(OP_LDA,10),
                    8'h05, 8'h00, 5'd10, 8'h05, 5'd2, 8'd12);

    // Directed programs: zero-wait with exact latency, then random waits with idle-ack noise.
    for (int pass = 0; pass < 2; pass++) begin
      for (int v = 0; v < 7; v++) begin
        for (int i = 0; i < DEPTH; i++) img[i] = '0;
        for (int i = 0; i < 4; i++) img[i] = vecs[v].code[i];
        img[31] = vecs[v].w31;
        img[10] = vecs[v].d10;
        img[11] = vecs[v].d11;
        model_run(m_halted, m_hpc, m_cyc);
        noise = (pass == 1);
        do_reset();
        run_to_halt((pass == 1) ? 5 : 0, vecs[v].halt_pc,
                    (pass == 1) ? 0 : int'(vecs[v].cycles), $sformatf("vec%0d_p%0d", v, pass));
        check($sformatf("vec%0d_p%0d_chk", v, pass), 32'(mem[vecs[v].chk_addr]),
              32'(vecs[v].chk_val));
      end
    end

    // Reset while an operand read is stalled; the ack lands during reset and must be discarded.
    noise = 1'b0;
    for (int i = 0; i < DEPTH; i++) img[i] = '0;
    img[0] = enc(OP_LDA, 10);
    img[10] = 8'h5A;
    do_reset();
    stall = 1'b1;
    stall_addr = 5'd10;
    max_wait = 0;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      tick();
      if (bus.mem_req && !bus.mem_we && bus.mem_addr == 5'd10) found = 1;
    end
    check("t6_reach_operand", 32'(found), 32'd1);
    check("t6_pc_inc", 32'(pc_out), 32'd1);
    repeat (3) tick();
    check("t6_req_hold", 32'(bus.mem_req), 32'd1);
    rst = 1'b1;
    stall = 1'b0;
    tick();
    check("t6_req_drop", 32'(bus.mem_req), 32'd0);
    check("t6_pc_reset", 32'(pc_out), 32'd0);
    check("t6_halt", 32'(halt), 32'd0);
    for (int i = 0; i < DEPTH; i++) img[i] = '0;
    img[0] = enc(OP_STO, 12);
    img[1] = enc(OP_HLT, 0);
    img[12] = 8'hEE;
    for (int i = 0; i < DEPTH; i++) mem[i] = img[i];
    model_run(m_halted, m_hpc, m_cyc);
    tick();
    obs_q.delete();
    in_txn = 1'b0;
    rst = 1'b0;
    tick();
    check("t6_fetch_req", 32'(bus.mem_req), 32'd1);
    check("t6_fetch_addr", 32'(bus.mem_addr), 32'd0);
    check("t6_fetch_we", 32'(bus.mem_we), 32'd0);
    run_to_halt(0, 5'd2, 0, "t6");
    check("t6_ac_zero", 32'(mem[12]), 32'd0);

    // Random programs checked against the ISA model.
    done = 0;
    tries = 0;
    while (done < 20 && tries < 400) begin
      tries++;
      for (int i = 0; i < DEPTH; i++) img[i] = DW'($urandom);
      model_run(m_halted, m_hpc, m_cyc);
      if (m_halted) begin
        noise = 1'b1;
        do_reset();
        run_to_halt(done % 6, m_hpc, 0, $sformatf("rand%0d", done));
        done++;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
